// File: rtl/vx_flush_unit.sv
// Per-bank cache flush engine: walks every line of the tag/data store and
// writes each valid+dirty line to DRAM with its dirty-byte mask, clearing
// dirty state after each accepted write and optionally invalidating lines.
module vx_flush_unit #(
    parameter int CACHE_SIZE     = 0,
    parameter int BANK_LINE_SIZE = 0,
    parameter int NUM_BANKS      = 0,
    parameter int WORD_SIZE      = 0,
    parameter int BANK_ID        = 0,
    // Guarded derivations so zero defaults still elaborate to legal widths
    localparam int BLS              = (BANK_LINE_SIZE > 0) ? BANK_LINE_SIZE : 1,
    localparam int NB               = (NUM_BANKS > 0) ? NUM_BANKS : 1,
    localparam int WS               = (WORD_SIZE > 0 && WORD_SIZE <= BLS) ? WORD_SIZE : BLS,
    localparam int LINES_RAW        = CACHE_SIZE / (BLS * NB),
    localparam int LINES            = (LINES_RAW > 0) ? LINES_RAW : 1,
    localparam int LINE_SELECT_BITS = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int BANK_BITS        = $clog2(NB),
    localparam int OFFSET_BITS      = $clog2(WS) + $clog2(BLS / WS),
    localparam int TAG_SELECT_BITS  = 32 - OFFSET_BITS - LINE_SELECT_BITS - BANK_BITS,
    localparam int BANK_LINE_WIDTH  = 8 * BLS,
    localparam int DRAM_ADDR_WIDTH  = TAG_SELECT_BITS + LINE_SELECT_BITS + BANK_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_req,
    input  logic                        flush_invalidate,
    output logic                        flush_busy,
    output logic                        flush_done,
    output logic [LINE_SELECT_BITS-1:0] ts_read_addr,
    input  logic                        ts_read_valid,
    input  logic                        ts_read_dirty,
    input  logic [BLS-1:0]              ts_read_dirtyb,
    input  logic [TAG_SELECT_BITS-1:0]  ts_read_tag,
    input  logic [BANK_LINE_WIDTH-1:0]  ts_read_data,
    output logic [LINE_SELECT_BITS-1:0] ts_write_addr,
    output logic                        ts_fill_sent,
    output logic                        ts_invalidate,
    output logic                        dram_req_valid,
    input  logic                        dram_req_ready,
    output logic                        dram_req_rw,
    output logic [DRAM_ADDR_WIDTH-1:0]  dram_req_addr,
    output logic [BLS-1:0]              dram_req_byteen,
    output logic [BANK_LINE_WIDTH-1:0]  dram_req_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [LINE_SELECT_BITS-1:0] LAST_IDX = LINE_SELECT_BITS'(LINES - 1);

    state_t                        state, state_n;
    logic [LINE_SELECT_BITS-1:0]   idx, idx_n;
    logic                          inval_r, inval_n;
    logic                          load;
    logic [TAG_SELECT_BITS-1:0]    tag_r;
    logic [BANK_LINE_WIDTH-1:0]    data_r;
    logic [BLS-1:0]                byteen_r;
    logic                          last;

    assign last = (idx == LAST_IDX);

    // State, line counter, invalidate latch and held DRAM payload
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            inval_r  <= 1'b0;
            tag_r    <= '0;
            data_r   <= '0;
            byteen_r <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            inval_r <= inval_n;
            if (load) begin
                tag_r    <= ts_read_tag;
                data_r   <= ts_read_data;
                byteen_r <= ts_read_dirtyb;
            end
        end
    end

    // Next-state, counter advance and store-control outputs
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        inval_n       = inval_r;
        load          = 1'b0;
        ts_fill_sent  = 1'b0;
        ts_invalidate = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (flush_req) begin
                    inval_n = flush_invalidate;
                    idx_n   = '0;
                    state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                if (ts_read_valid && ts_read_dirty) begin
                    load    = 1'b1;
                    state_n = S_SEND;
                end else begin
                    ts_invalidate = inval_r && ts_read_valid;
                    if (last) state_n = S_DONE;
                    else      idx_n   = idx + 1'b1;
                end
            end
            S_SEND: begin
                if (dram_req_ready) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                ts_fill_sent  = 1'b1;
                ts_invalidate = inval_r;
                if (last) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = S_SCAN;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign flush_busy      = (state != S_IDLE);
    assign flush_done      = (state == S_DONE);
    assign dram_req_valid  = (state == S_SEND);
    assign dram_req_rw     = 1'b1;
    assign ts_read_addr    = idx;
    assign ts_write_addr   = idx;
    assign dram_req_byteen = byteen_r;
    assign dram_req_data   = data_r;

    // Bank field is appended only when there is more than one bank
    if (BANK_BITS > 0) begin : g_bank_addr
        localparam logic [BANK_BITS-1:0] BANK_FIELD = BANK_BITS'(BANK_ID);
        assign dram_req_addr = {tag_r, idx, BANK_FIELD};
    end else begin : g_single_bank_addr
        assign dram_req_addr = {tag_r, idx};
    end

endmodule
